cnn_window_gen: RTL and testbench
=================================

Name: cnn_window_gen

Overview:
- Sliding-window generator directly upstream of cnn_core.
- Accepts one raster-order pixel per valid cycle (all CI channels in parallel) and keeps KY-1 line buffers plus a KY x KX window register.
- Emits one complete KX x KY x CI window, packed exactly as cnn_core's i_in_fmap, for every valid-convolution output position (stride 1, no padding).
- No backpressure; cnn_core accepts every valid beat.

Parameters:
- CI, 3, input channels per pixel.
- KX, 3, kernel width.
- KY, 3, kernel height.
- I_F_BW, 8, bits per channel sample.
- IMG_W, 8, frame width in pixels (>= KX).
- IMG_H, 8, frame height in pixels (>= KY).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- i_soft_reset  in  1  synchronous clear of counters and valid outputs.
- i_in_valid  in  1  pixel beat valid.
- i_in_pixel  in  CI*I_F_BW  pixel; channel c at [c*I_F_BW +: I_F_BW].
- o_ot_valid  out  1  window valid; feeds cnn_core i_in_valid.
- o_ot_fmap  out  CI*KX*KY*I_F_BW  window; feeds cnn_core i_in_fmap.
- o_frame_done  out  1  one-cycle pulse, co-timed with the window of the last pixel of a frame.

Behaviour:
- Reset (reset_n low, asynchronous): col/row counters = 0, o_ot_valid = 0, o_frame_done = 0, o_ot_fmap = 0. Line buffer RAM contents are don't-care.
- i_soft_reset (synchronous, highest priority after reset_n): same clears as reset. Window and line-buffer data may be left as is. The next accepted pixel is treated as (row 0, col 0).
- Only beats with i_in_valid=1 advance state. Idle cycles between beats are allowed and freeze everything. o_ot_valid drops to 0 on idle cycles.
- Counters: col runs 0..IMG_W-1. On col=IMG_W-1, col wraps to 0 and row increments. row runs 0..IMG_H-1 and wraps to 0 after the last pixel; the next frame starts immediately.
- Line buffers: buffer k (k=0..KY-2) holds row r-1-k at each column. On an accepted beat at column c, buffer 0[c] <= pixel, buffer k[c] <= old buffer k-1[c], all on the same edge.
- Window shift: on each accepted beat every window row shifts left by one column. The new rightmost column (kx=KX-1) is: ky=KY-1 from i_in_pixel; ky=KY-2-k from old buffer k[c].
- Output packing: element (ci, ky, kx) at [((ci*KY + ky)*KX + kx)*I_F_BW +: I_F_BW]. ky=0 is the top (oldest) row; kx=0 is the leftmost (oldest) column.
- Valid rule: o_ot_valid=1 in the cycle after accepting pixel (r,c) iff r >= KY-1 and c >= KX-1. This gives (IMG_W-KX+1)*(IMG_H-KY+1) windows per frame.
- Latency: exactly 1 clock from accepted pixel to window. o_ot_fmap holds its last value when o_ot_valid=0.
- Windows never straddle a row boundary: invalid positions c < KX-1 are suppressed even though the window register holds mixed-row data.
- o_frame_done: asserted with the window for pixel (IMG_H-1, IMG_W-1).
- Simultaneous i_soft_reset and i_in_valid: the soft reset wins and the pixel is dropped.
- Widths: pure data movement, no arithmetic on samples. Counters are $clog2(IMG_W) and $clog2(IMG_H) bits wide.

Test Plan:
- CI=1, KX=KY=3, IMG_W=IMG_H=4, pixel=row*4+col streamed back-to-back -> first o_ot_valid one cycle after pixel 10. The window, reading (ky,kx) row-major, is 0,1,2,4,5,6,8,9,10. The four windows end at pixels 10, 11, 14, 15. o_frame_done accompanies the window ending at 15.
- Same stream with random 0-3 idle cycles between beats -> identical four windows in order. o_ot_valid is never high on an idle-following cycle without a new beat.
- Two frames back-to-back, the second with pixel=100+idx -> the second frame's first window is 100,101,102,104,105,106,108,109,110. No window mixes frame data before row 2 of the second frame.
- CI=3, channel c = 16*c + idx -> each channel slice matches the single-channel expectation, offset by 16*c, at the specified bit positions.
- Assert i_soft_reset after pixel 9 of a frame, then restart the stream from 0 -> no valid during or after the soft reset until the new pixel 10. The output then matches the first scenario.
- Assert reset_n mid-frame asynchronously -> o_ot_valid and o_frame_done go to 0 immediately. Counters restart at (0,0).

Source files
------------

// File: rtl/cnn_window_gen.sv
// cnn_window_gen: raster-order sliding-window generator feeding cnn_core.
// Keeps KY-1 line buffers and a KY x KX window register. For every
// stride-1, no-padding convolution position it emits one packed
// KX x KY x CI window, one clock after the pixel that completes it.
module cnn_window_gen #(
  parameter int CI     = 3,
  parameter int KX     = 3,
  parameter int KY     = 3,
  parameter int I_F_BW = 8,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         i_soft_reset,
  input  logic                         i_in_valid,
  input  logic [CI*I_F_BW-1:0]         i_in_pixel,
  output logic                         o_ot_valid,
  output logic [CI*KX*KY*I_F_BW-1:0]   o_ot_fmap,
  output logic                         o_frame_done
);

  localparam int PW = CI * I_F_BW;
  localparam int FW = PW * KX * KY;
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(KX - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(KY - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;

  // line_buf[k][c] holds the pixel of row r-1-k at column c
  logic [PW-1:0] line_buf [KY-1][IMG_W];
  logic [PW-1:0] win      [KY][KX];
  logic [PW-1:0] win_nxt  [KY][KX];
  logic [FW-1:0] fmap_nxt;
  logic          accept;
  logic          pos_valid;
  logic          pos_last;

  // A soft reset drops any pixel presented in the same cycle
  assign accept    = i_in_valid & ~i_soft_reset;
  assign pos_valid = (row >= ROW_FIRST) && (col >= COL_FIRST);
  assign pos_last  = (row == ROW_LAST) && (col == COL_LAST);

  // Next window: shift left, fill the right column from the line buffers and the new pixel
  always_comb begin
    for (int unsigned ky = 0; ky < KY; ky++) begin
      for (int unsigned kx = 0; kx < KX; kx++) begin
        win_nxt[ky][kx] = '0;
      end
    end
    for (int unsigned ky = 0; ky < KY; ky++) begin
      for (int unsigned kx = 0; kx + 1 < KX; kx++) begin
        win_nxt[ky][kx] = win[ky][kx+1];
      end
    end
    for (int unsigned k = 0; k + 1 < KY; k++) begin
      win_nxt[KY-2-k][KX-1] = line_buf[k][col];
    end
    win_nxt[KY-1][KX-1] = i_in_pixel;
  end

  // Pack the next window in cnn_core order: channel-major, then ky, then kx
  always_comb begin
    fmap_nxt = '0;
    for (int unsigned ci = 0; ci < CI; ci++) begin
      for (int unsigned ky = 0; ky < KY; ky++) begin
        for (int unsigned kx = 0; kx < KX; kx++) begin
          fmap_nxt[((ci*KY + ky)*KX + kx)*I_F_BW +: I_F_BW] =
            win_nxt[ky][kx][ci*I_F_BW +: I_F_BW];
        end
      end
    end
  end

  // Data path: window shift and line-buffer cascade, no reset needed
  always_ff @(posedge clk) begin
    if (accept) begin
      win <= win_nxt;
      line_buf[0][col] <= i_in_pixel;
      for (int unsigned k = 1; k + 1 < KY; k++) begin
        line_buf[k][col] <= line_buf[k-1][col];
      end
    end
  end

  // Control: raster counters and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col          <= '0;
      row          <= '0;
      o_ot_valid   <= 1'b0;
      o_frame_done <= 1'b0;
      o_ot_fmap    <= '0;
    end else if (i_soft_reset) begin
      col          <= '0;
      row          <= '0;
      o_ot_valid   <= 1'b0;
      o_frame_done <= 1'b0;
      o_ot_fmap    <= '0;
    end else if (accept) begin
      o_ot_valid   <= pos_valid;
      o_frame_done <= pos_last;
      if (pos_valid) begin
        o_ot_fmap <= fmap_nxt;
      end
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end else begin
      o_ot_valid   <= 1'b0;
      o_frame_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cnn_window_gen.sv
// Self-checking bench for cnn_window_gen (CI=3, 3x3 kernel, 4x4 frame).
// A frame-image reference model predicts every window from pixel coordinates.
module tb_cnn_window_gen;

  localparam int CI = 3, KX = 3, KY = 3, W = 8, IMG_W = 4, IMG_H = 4;
  localparam int PW = CI * W;
  localparam int FW = PW * KX * KY;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          i_soft_reset = 1'b0;
  logic          i_in_valid = 1'b0;
  logic [PW-1:0] i_in_pixel = '0;
  logic          o_ot_valid;
  logic [FW-1:0] o_ot_fmap;
  logic          o_frame_done;

  cnn_window_gen #(
    .CI(CI), .KX(KX), .KY(KY), .I_F_BW(W), .IMG_W(IMG_W), .IMG_H(IMG_H)
  ) dut (
    .clk(clk), .reset_n(reset_n), .i_soft_reset(i_soft_reset),
    .i_in_valid(i_in_valid), .i_in_pixel(i_in_pixel),
    .o_ot_valid(o_ot_valid), .o_ot_fmap(o_ot_fmap), .o_frame_done(o_frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [PW-1:0] img [IMG_H][IMG_W];
  int            mr = 0, mc = 0;
  logic          exp_valid = 1'b0, exp_done = 1'b0;
  logic [FW-1:0] exp_fmap = '0;

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk_pix(input int base);
    logic [PW-1:0] p;
    for (int c = 0; c < CI; c++) p[c*W +: W] = W'(base + 16*c);
    return p;
  endfunction

  // Hand-derived first window of a 4-wide frame starting at 'base'
  function automatic logic [FW-1:0] first_win(input int base);
    int offs [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    logic [FW-1:0] f;
    for (int ci = 0; ci < CI; ci++)
      for (int k = 0; k < 9; k++)
        f[(ci*9 + k)*W +: W] = W'(base + offs[k] + 16*ci);
    return f;
  endfunction

  task automatic model_reset();
    mr = 0; mc = 0;
    exp_valid = 1'b0; exp_done = 1'b0; exp_fmap = '0;
  endtask

  // Window = the KY x KX block of the current frame ending at (mr, mc)
  task automatic model_beat(input logic [PW-1:0] pix);
    img[mr][mc] = pix;
    exp_valid = (mr >= KY-1) && (mc >= KX-1);
    exp_done  = (mr == IMG_H-1) && (mc == IMG_W-1);
    if (exp_valid)
      for (int ci = 0; ci < CI; ci++)
        for (int ky = 0; ky < KY; ky++)
          for (int kx = 0; kx < KX; kx++)
            exp_fmap[((ci*KY + ky)*KX + kx)*W +: W] =
              img[mr-(KY-1)+ky][mc-(KX-1)+kx][ci*W +: W];
    mc++;
    if (mc == IMG_W) begin
      mc = 0;
      mr = (mr == IMG_H-1) ? 0 : mr + 1;
    end
  endtask

  task automatic tick(input logic v, input logic sr, input logic [PW-1:0] pix);
    i_in_valid = v; i_soft_reset = sr; i_in_pixel = pix;
    @(posedge clk);
    if (sr) model_reset();
    else if (v) model_beat(pix);
    else begin exp_valid = 1'b0; exp_done = 1'b0; end
    #1;
    chk("valid", FW'(o_ot_valid), FW'(exp_valid));
    chk("frame_done", FW'(o_frame_done), FW'(exp_done));
    chk("fmap", o_ot_fmap, exp_fmap);
    i_in_valid = 1'b0; i_soft_reset = 1'b0;
  endtask

  task automatic stream(input int base, input int max_idle, input int upto,
                        input logic chk_win, output logic [15:0] vmask,
                        output logic [15:0] dmask);
    vmask = '0; dmask = '0;
    for (int idx = 0; idx <= upto; idx++) begin
      int idle = $urandom_range(0, max_idle);
      for (int i = 0; i < idle; i++) tick(1'b0, 1'b0, PW'($urandom));
      tick(1'b1, 1'b0, mk_pix(base + idx));
      if (o_ot_valid) vmask[idx] = 1'b1;
      if (o_frame_done) dmask[idx] = 1'b1;
      if (chk_win && idx == 10) chk("first_window", o_ot_fmap, first_win(base));
    end
  endtask

  logic [15:0] vm, dm;

  initial begin
    // Reset state
    #12;
    chk("reset_valid", FW'(o_ot_valid), '0);
    chk("reset_done", FW'(o_frame_done), '0);
    chk("reset_fmap", o_ot_fmap, '0);
    reset_n = 1'b1;
    model_reset();

    // Back-to-back frame of row*4+col
    stream(0, 0, 15, 1'b1, vm, dm);
    chk("b2b_vmask", FW'(vm), FW'(16'hCC00));
    chk("b2b_dmask", FW'(dm), FW'(16'h8000));

    // Same frame with random idle gaps
    stream(0, 3, 15, 1'b1, vm, dm);
    chk("idle_vmask", FW'(vm), FW'(16'hCC00));
    chk("idle_dmask", FW'(dm), FW'(16'h8000));

    // Second frame immediately following, pixel = 100+idx
    stream(100, 0, 15, 1'b1, vm, dm);
    chk("frame2_vmask", FW'(vm), FW'(16'hCC00));

    // Soft reset after pixel 9, colliding with a beat that must be dropped
    stream(0, 1, 9, 1'b0, vm, dm);
    chk("pre_sr_vmask", FW'(vm), '0);
    tick(1'b1, 1'b1, mk_pix(200));
    tick(1'b0, 1'b1, '0);
    stream(0, 0, 15, 1'b1, vm, dm);
    chk("post_sr_vmask", FW'(vm), FW'(16'hCC00));
    chk("post_sr_dmask", FW'(dm), FW'(16'h8000));

    // Async reset right after the frame_done window
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", FW'(o_ot_valid), '0);
    chk("arst_done", FW'(o_frame_done), '0);
    chk("arst_fmap", o_ot_fmap, '0);
    model_reset();
    #3 reset_n = 1'b1;

    // Async reset mid-frame, then a full frame must restart at (0,0)
    stream(50, 1, 6, 1'b0, vm, dm);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_mid_valid", FW'(o_ot_valid), '0);
    model_reset();
    #3 reset_n = 1'b1;
    stream(0, 2, 15, 1'b1, vm, dm);
    chk("arst_restart_vmask", FW'(vm), FW'(16'hCC00));

    // Random pixels, gaps and occasional soft resets against the model
    for (int n = 0; n < 400; n++) begin
      int r = $urandom_range(0, 99);
      if (r < 3) tick(1'($urandom), 1'b1, PW'($urandom));
      else if (r < 25) tick(1'b0, 1'b0, PW'($urandom));
      else tick(1'b1, 1'b0, PW'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
